// File: rtl/mc_step_sched_pkg.sv
// Shared types and constants for the mc_step_sched channel sequencer.
package mc_pkg;

  localparam int MAX_PORTS = 32;

  localparam int DEF_CH_W  = 6;
  localparam int DEF_TM_W  = 24;
  localparam int DEF_RPT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } mc_state_e;

endpackage

// File: rtl/mc_step_timer.sv
// Loadable down-counter shared by the ON and GAP phases; zero_o marks the final cycle.
module mc_step_timer #(
  parameter int TM_W = 24
) (
  input  logic            io_clk,
  input  logic            io_rst,
  input  logic            load_i,
  input  logic [TM_W-1:0] load_val_i,
  output logic            zero_o
);

  logic [TM_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TM_W'(1);
    end
  end

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mc_step_sched.sv
// Timed channel-step scheduler: walks channels 0..portNo-1 for RptNo rounds.
// Define MC_STEP_SCHED_RETRIG_EN to let io_catch restart a run that is in progress.
//
// state | meaning
// IDLE  | waiting for io_catch
// ON    | ctrl valid, on-time timer running
// GAP   | idle gap between steps, gap timer running
// DONE  | single-cycle completion pulse
module mc_step_sched
  import mc_pkg::*;
#(
  parameter int CH_W  = DEF_CH_W,
  parameter int TM_W  = DEF_TM_W,
  parameter int RPT_W = DEF_RPT_W
) (
  input  logic             io_clk,
  input  logic             io_rst,
  input  logic             io_catch,
  input  logic             io_abort,
  input  logic [CH_W-1:0]  io_portNo,
  input  logic [RPT_W-1:0] io_RptNo,
  input  logic [TM_W-1:0]  io_onTime,
  input  logic [TM_W-1:0]  io_gapTime,
  output logic [CH_W-1:0]  ctrl,
  output logic             ctrl_valid,
  output logic             io_stepStart,
  output logic             io_busy,
  output logic             io_done,
  output logic [RPT_W-1:0] io_round
);

  mc_state_e        state_q, state_d;
  logic [CH_W-1:0]  ctrl_q, ctrl_d;
  logic [RPT_W-1:0] round_q, round_d;
  logic             step_q, step_d;

  logic [CH_W-1:0]  port_q;
  logic [RPT_W-1:0] rpt_q;
  logic [TM_W-1:0]  on_m1_q;
  logic [TM_W-1:0]  gap_q;

  logic             start, cfg_ld, tmr_load, tmr_zero;
  logic [TM_W-1:0]  tmr_val;
  logic [CH_W-1:0]  port_eff, nxt_ctrl;
  logic [RPT_W-1:0] nxt_round;
  logic [TM_W-1:0]  on_in_m1;
  logic             wrap, last;

  assign port_eff = (io_portNo > CH_W'(MAX_PORTS)) ? CH_W'(MAX_PORTS) : io_portNo;
  assign on_in_m1 = (io_onTime == '0) ? '0 : io_onTime - TM_W'(1);

  assign wrap      = (ctrl_q == port_q - CH_W'(1));
  assign last      = wrap && (round_q == rpt_q - RPT_W'(1));
  assign nxt_ctrl  = wrap ? '0 : ctrl_q + CH_W'(1);
  assign nxt_round = wrap ? round_q + RPT_W'(1) : round_q;

`ifdef MC_STEP_SCHED_RETRIG_EN
  assign start = io_catch;
`else
  assign start = io_catch && (state_q == ST_IDLE);
`endif

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    round_d  = round_q;
    step_d   = 1'b0;
    cfg_ld   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = on_m1_q;
    if (io_abort) begin
      state_d = ST_IDLE;
      ctrl_d  = '0;
      round_d = '0;
    end else if (start) begin
      // Decide from the live inputs; the latched copy is not valid until next cycle
      cfg_ld  = 1'b1;
      ctrl_d  = '0;
      round_d = '0;
      if (port_eff == '0 || io_RptNo == '0) begin
        state_d = ST_DONE;
      end else begin
        state_d  = ST_ON;
        step_d   = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = on_in_m1;
      end
    end else begin
      case (state_q)
        ST_ON: begin
          if (tmr_zero) begin
            if (gap_q != '0) begin
              state_d  = ST_GAP;
              tmr_load = 1'b1;
              tmr_val  = gap_q - TM_W'(1);
            end else if (last) begin
              state_d = ST_DONE;
            end else begin
              step_d   = 1'b1;
              tmr_load = 1'b1;
              ctrl_d   = nxt_ctrl;
              round_d  = nxt_round;
            end
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            if (last) begin
              state_d = ST_DONE;
            end else begin
              state_d  = ST_ON;
              step_d   = 1'b1;
              tmr_load = 1'b1;
              ctrl_d   = nxt_ctrl;
              round_d  = nxt_round;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          ctrl_d  = '0;
          round_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      round_q <= '0;
      step_q  <= 1'b0;
      port_q  <= '0;
      rpt_q   <= '0;
      on_m1_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      round_q <= round_d;
      step_q  <= step_d;
      if (cfg_ld) begin
        port_q  <= port_eff;
        rpt_q   <= io_RptNo;
        on_m1_q <= on_in_m1;
        gap_q   <= io_gapTime;
      end
    end
  end

  mc_step_timer #(.TM_W(TM_W)) u_timer (
    .io_clk     (io_clk),
    .io_rst     (io_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign ctrl         = ctrl_q;
  assign ctrl_valid   = (state_q == ST_ON);
  assign io_stepStart = step_q;
  assign io_busy      = (state_q != ST_IDLE);
  assign io_done      = (state_q == ST_DONE);
  assign io_round     = round_q;

endmodule

// File: tb/tb_mc_step_sched.sv
// Scoreboard bench for mc_step_sched; expected step/done events come from a schedule model.
module tb_mc_step_sched;

  logic        io_clk = 1'b0;
  logic        io_rst, io_catch, io_abort;
  logic [5:0]  io_portNo;
  logic [15:0] io_RptNo;
  logic [23:0] io_onTime, io_gapTime;
  logic [5:0]  ctrl;
  logic        ctrl_valid, io_stepStart, io_busy, io_done;
  logic [15:0] io_round;

  mc_step_sched dut (
    .io_clk       (io_clk),
    .io_rst       (io_rst),
    .io_catch     (io_catch),
    .io_abort     (io_abort),
    .io_portNo    (io_portNo),
    .io_RptNo     (io_RptNo),
    .io_onTime    (io_onTime),
    .io_gapTime   (io_gapTime),
    .ctrl         (ctrl),
    .ctrl_valid   (ctrl_valid),
    .io_stepStart (io_stepStart),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_round     (io_round)
  );

  always #5 io_clk = ~io_clk;

  typedef struct {
    bit is_done;
    int ch;
    int rnd;
    int cyc;
    int on;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cut_cyc = -1;
  int   run_end = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Events a DUT would no longer produce once it has been stopped at cycle 'from'
  task automatic purge(input int from);
    exp_t keep[$];
    foreach (q[i]) if (q[i].cyc < from) keep.push_back(q[i]);
    q = keep;
  endtask

  task automatic push_run(input int p, input int r, input int on, input int gap, input int tc);
    int pe, one, per, n;
    pe  = (p > 32) ? 32 : p;
    one = (on == 0) ? 1 : on;
    per = one + gap;
    n   = pe * r;
    for (int k = 0; k < n; k++) q.push_back('{1'b0, k % pe, k / pe, tc + k * per, one});
    q.push_back('{1'b1, 0, 0, tc + n * per, 0});
    run_end = tc + n * per;
  endtask

  task automatic drive_cfg(input int p, input int r, input int on, input int gap);
    io_portNo  = 6'(p);
    io_RptNo   = 16'(r);
    io_onTime  = 24'(on);
    io_gapTime = 24'(gap);
  endtask

  task automatic catch_run(input int p, input int r, input int on, input int gap, output int tc);
    @(negedge io_clk);
    drive_cfg(p, r, on, gap);
    io_catch = 1'b1;
    tc = cyc + 1;
    if (tc - 1 > run_end) begin
      push_run(p, r, on, gap, tc);
    end else begin
`ifdef MC_STEP_SCHED_RETRIG_EN
      purge(tc);
      cut_cyc = tc;
      push_run(p, r, on, gap, tc);
`endif
    end
    @(negedge io_clk);
    io_catch = 1'b0;
    // Config written mid-run must not disturb the latched schedule
    drive_cfg($urandom_range(0, 63), $urandom_range(0, 9), $urandom_range(0, 20), $urandom_range(0, 9));
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge io_clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((io_busy || q.size() != 0) && n < budget) begin
      @(negedge io_clk);
      n++;
    end
    if (n >= budget) begin
      chk("idle_timeout_busy", int'(io_busy), 0);
      chk("idle_timeout_queue", q.size(), 0);
    end
    repeat (2) @(negedge io_clk);
  endtask

  task automatic do_abort();
    int ea;
    io_abort = 1'b1;
    ea = cyc + 1;
    purge(ea);
    cut_cyc = ea;
    run_end = ea - 1;
    @(posedge io_clk);
    #2;
    chk("abort_valid", int'(ctrl_valid), 0);
    chk("abort_busy", int'(io_busy), 0);
    chk("abort_done", int'(io_done), 0);
    @(negedge io_clk);
    io_abort = 1'b0;
  endtask

  task automatic do_reset_mid();
    int er;
    io_rst = 1'b1;
    er = cyc + 1;
    purge(er);
    cut_cyc = er;
    run_end = er - 1;
    @(posedge io_clk);
    #2;
    chk("rst_ctrl", int'(ctrl), 0);
    chk("rst_valid", int'(ctrl_valid), 0);
    chk("rst_step", int'(io_stepStart), 0);
    chk("rst_busy", int'(io_busy), 0);
    chk("rst_done", int'(io_done), 0);
    chk("rst_round", int'(io_round), 0);
    @(negedge io_clk);
    io_rst = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each rising edge
  bit prev_valid = 1'b0;
  int vcnt = 0;
  int cur_on = 0;
  bit chk_idle = 1'b0;

  always begin
    exp_t e;
    @(posedge io_clk);
    cyc++;
    #1;
    if (chk_idle && cyc != cut_cyc) chk("idle_after_done", int'(io_busy), 0);
    chk_idle = 1'b0;
    if (prev_valid && (!ctrl_valid || io_stepStart) && cyc != cut_cyc)
      chk("on_len", vcnt, cur_on);
    if (ctrl_valid) chk("valid_implies_busy", int'(io_busy), 1);
    if (io_stepStart || io_done) begin
      if (q.size() == 0) begin
        chk("event_with_empty_queue", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("event_kind", int'(io_done), int'(e.is_done));
        chk("event_cyc", cyc, e.cyc);
        if (e.is_done) begin
          chk_idle = 1'b1;
        end else begin
          chk("step_ctrl", int'(ctrl), e.ch);
          chk("step_round", int'(io_round), e.rnd);
          chk("step_valid", int'(ctrl_valid), 1);
          cur_on = e.on;
        end
      end
    end
    if (io_stepStart) vcnt = 1;
    else if (ctrl_valid) vcnt++;
    else vcnt = 0;
    prev_valid = ctrl_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc, tc2, p, r;
    io_rst   = 1'b1;
    io_catch = 1'b0;
    io_abort = 1'b0;
    drive_cfg(0, 0, 0, 0);
    repeat (3) @(negedge io_clk);
    chk("reset_ctrl", int'(ctrl), 0);
    chk("reset_valid", int'(ctrl_valid), 0);
    chk("reset_step", int'(io_stepStart), 0);
    chk("reset_busy", int'(io_busy), 0);
    chk("reset_done", int'(io_done), 0);
    chk("reset_round", int'(io_round), 0);
    io_rst = 1'b0;
    repeat (5) @(negedge io_clk);

    catch_run(3, 2, 4, 2, tc);  wait_idle(500);
    catch_run(2, 1, 0, 0, tc);  wait_idle(500);
    catch_run(0, 3, 2, 2, tc);  wait_idle(500);
    catch_run(4, 0, 1, 1, tc);  wait_idle(500);
    catch_run(40, 1, 1, 0, tc); wait_idle(500);

    // Abort in the gap after round 1, channel 2, then a clean restart
    catch_run(3, 2, 4, 2, tc);
    wait_cyc(tc + 34);
    do_abort();
    wait_idle(500);
    catch_run(3, 2, 4, 2, tc); wait_idle(500);

    // Second trigger mid-run
    catch_run(3, 2, 3, 1, tc);
    wait_cyc(tc + 10);
    catch_run(2, 1, 2, 0, tc2);
    wait_idle(500);

    catch_run(4, 2, 5, 1, tc);
    wait_cyc(tc + 2);
    do_reset_mid();
    wait_idle(500);

    for (int i = 0; i < 16; i++) begin
      p = ($urandom_range(0, 7) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 5);
      r = (p > 32) ? 1 : $urandom_range(0, 3);
      catch_run(p, r, $urandom_range(0, 5), $urandom_range(0, 3), tc);
      wait_idle(2000);
      repeat ($urandom_range(0, 3)) @(negedge io_clk);
    end

    wait_idle(2000);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_step_sched.md
Name: mc_step_sched

Overview:
- Sequencer that drives the per-channel output controller in the multichannel logic top. It replaces free-running channel stepping with a timed schedule.
- On a trigger it walks channel indices 0..portNo-1, holding each for a programmable on-time followed by a programmable gap. It repeats the walk RptNo times.
- Emits the channel index/valid consumed by the output controller and counters, plus busy/done status for the bus.

Parameters:
- CH_W, 6, width of channel index and port count
- TM_W, 24, width of on-time/gap timers (matches pulse-width fields)
- RPT_W, 16, width of repeat count

Ports:
- io_clk  in  1  clock
- io_rst  in  1  synchronous active-high reset
- io_catch  in  1  single-cycle trigger (external catch or bus trigger, already muxed)
- io_abort  in  1  stop sequence immediately
- io_portNo  in  CH_W  channels per round; legal range 0..32
- io_RptNo  in  RPT_W  number of rounds
- io_onTime  in  TM_W  cycles each channel is active
- io_gapTime  in  TM_W  idle cycles between channels
- ctrl  out  CH_W  current channel index
- ctrl_valid  out  1  ctrl is active (high in ON state only)
- io_stepStart  out  1  one-cycle pulse on first ON cycle of each step
- io_busy  out  1  high in ON/GAP/DONE
- io_done  out  1  one-cycle pulse on normal completion
- io_round  out  RPT_W  current round index, 0-based

Behaviour:
- Reset values: ctrl=0, ctrl_valid=0, io_stepStart=0, io_busy=0, io_done=0, io_round=0, state IDLE. Reset mid-sequence forces IDLE on the next edge; no done pulse.
- Config (portNo, RptNo, onTime, gapTime) is latched on the accepted io_catch. Bus writes during a run have no effect until the next trigger.
- Effective values: onTime=0 is treated as 1. gapTime=0 means no GAP state. portNo>32 is clamped to 32.
- States:
  - IDLE -> ON when io_catch, portNo≠0 and RptNo≠0.
  - IDLE -> DONE when io_catch and (portNo==0 or RptNo==0).
  - ON: timer counts effective onTime cycles. Leaving ON:
    - to GAP if gap≠0;
    - else to ON with next channel;
    - else to DONE if this was the last step.
  - GAP: gapTime cycles, then ON with the next channel, or DONE if the step just finished was the last step.
  - DONE: one cycle, io_done=1, then IDLE.
- Last step: ctrl==portNo-1 and io_round==RptNo-1.
- Channel advance: ctrl increments. Wrap from portNo-1 to 0 increments io_round.
- Timing:
  - io_catch sampled at edge T; first ON cycle (ctrl=0, ctrl_valid=1, io_stepStart=1) is T+1.
  - Step period = onTime + gapTime cycles exactly.
  - Total busy cycles = portNo·RptNo·(on+gap) + 1, where the +1 is DONE. The trailing gap after the last step is included.
- io_abort: highest priority after reset. From any state it goes to IDLE next edge, clears ctrl_valid, and gives no io_done.
- io_catch while busy: ignored (without optional feature). io_catch and io_abort in the same cycle: abort wins, trigger dropped.
- Timers are down-counters loaded at state entry. No arithmetic overflow is possible since they load values ≤ 2^TM_W-1.

Optional Feature:
- Macro MC_STEP_SCHED_RETRIG_EN.
- Defined: io_catch while in ON/GAP/DONE re-latches config and restarts at ctrl=0, round 0, in ON on the next cycle. io_stepStart pulses; no io_done for the interrupted run.
- Undefined: triggers while busy are ignored.

Decomposition:
- Shared package mc_pkg holds:
  - state encoding typedef (IDLE, ON, GAP, DONE);
  - MAX_PORTS=32;
  - default widths CH_W/TM_W/RPT_W.
- One natural sub-module: mc_step_timer, a loadable TM_W down-counter with load/zero flag, instantiated once and shared between ON and GAP.

Test Plan:
- portNo=3, RptNo=2, onTime=4, gapTime=2, catch at cycle 10:
  - ctrl sequence 0,1,2,0,1,2 with ctrl_valid high 4 cycles each and stepStart at cycles 11,17,23,29,35,41;
  - io_round 0 then 1;
  - io_done at cycle 47; busy cycles 11..47.
- gapTime=0, onTime=0, portNo=2, RptNo=1:
  - ctrl=0 for 1 cycle, then ctrl=1 for 1 cycle, ctrl_valid continuous;
  - io_done on the third cycle after the catch edge.
- portNo=0 or RptNo=0 with catch: ctrl_valid never asserts; io_done pulses at T+1; busy only at T+1.
- Abort during GAP of round 1, channel 2: IDLE next cycle, ctrl_valid=0, no io_done. A following catch restarts at ctrl=0, round 0.
- Second catch mid-run:
  - without macro: ignored, schedule unchanged;
  - with MC_STEP_SCHED_RETRIG_EN: restart at ctrl=0 next cycle, stepStart pulses.
- io_rst asserted mid-ON: all outputs 0 next edge. Change io_onTime mid-run: current run unaffected, new value used on the next trigger.
